// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared state encoding and width helpers for the shift-add multiplier.
// Revision 1.0 - initial release
`default_nettype none

package seq_mult_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

   function automatic int calc_cw(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mult_dp.sv
// seq_mult_dp: operand/accumulator registers, N+1-bit adder and step counter.
// Revision 1.0 - initial release
`default_nettype none

module seq_mult_dp #(
   parameter int N  = 6,
   parameter int CW = 3
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           ld_i,
   input  logic           step_i,
   input  logic [N-1:0]   a_i,
   input  logic [N-1:0]   b_i,
   output logic           last_o,
   output logic [2*N-1:0] p_next_o
);

   logic [N-1:0]  a_q;
   logic [2*N:0]  p_q;
   logic [CW-1:0] cnt_q;
   logic [N:0]    upper;

   // Upper half is N+1 bits wide so the adder carry survives into the shift.
   always_comb begin
      upper = p_q[2*N:N];
      if (p_q[0]) begin
         upper = p_q[2*N:N] + {1'b0, a_q};
      end
   end

   assign p_next_o = {upper, p_q[N-1:1]};
   assign last_o   = (cnt_q == CW'(N - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q   <= '0;
         p_q   <= '0;
         cnt_q <= '0;
      end else if (ld_i) begin
         a_q   <= a_i;
         p_q   <= {{(N+1){1'b0}}, b_i};
         cnt_q <= '0;
      end else if (step_i) begin
         p_q   <= {1'b0, p_next_o};
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: FSM sequencing the shift-add datapath plus the product holding register.
// Revision 1.0 - initial release
`default_nettype none

module seq_mult_ctrl
   import seq_mult_pkg::*;
#(
   parameter int N = 6
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           abort,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product,
   output logic [1:0]     state_o
);

   localparam int CW = calc_cw(N);

   state_t         state_q, state_d;
   logic           ld, step, last;
   logic [2*N-1:0] p_next;
   logic [2*N-1:0] product_q;

   seq_mult_dp #(
      .N  (N),
      .CW (CW)
   ) u_dp (
      .clk      (clk),
      .reset    (reset),
      .ld_i     (ld),
      .step_i   (step),
      .a_i      (a),
      .b_i      (b),
      .last_o   (last),
      .p_next_o (p_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         product_q <= '0;
      end else begin
         state_q <= state_d;
         if (step && last) begin
            product_q <= p_next;
         end
      end
   end

   // Abort outranks the step; the illegal encoding falls back to IDLE.
   always_comb begin
      state_d = IDLE;
      ld      = 1'b0;
      step    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               ld      = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               step    = 1'b1;
               state_d = last ? DONE : CALC;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy    = (state_q == CALC) || (state_q == DONE);
   assign done    = (state_q == DONE);
   assign product = product_q;
   assign state_o = state_q;

endmodule

`default_nettype wire
